// File: rtl/candidate_collector.sv
// Candidate collector: merges near-duplicate classifier hits against the last
// kept hit, queues survivors in a FWFT FIFO, drains them over valid/ready and
// closes each frame with a one-cycle done pulse.
module candidate_collector #(
  parameter int unsigned DATA_WIDTH_12   = 12,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned MERGE_DIST      = 2,
  parameter int unsigned COUNT_WIDTH     = 12
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_inspect_done,
  input  logic                     i_candidate,
  input  logic [DATA_WIDTH_12-1:0] i_resize_x,
  input  logic [DATA_WIDTH_12-1:0] i_resize_y,
  input  logic                     i_frame_end,
  input  logic                     i_result_ready,
  output logic                     o_result_valid,
  output logic [DATA_WIDTH_12-1:0] o_result_x,
  output logic [DATA_WIDTH_12-1:0] o_result_y,
  output logic [COUNT_WIDTH-1:0]   o_count,
  output logic                     o_overflow,
  output logic                     o_frame_done,
  output logic                     o_busy
);

  localparam int unsigned OccW   = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned DiffW  = DATA_WIDTH_12 + 1;
  localparam int unsigned EntryW = 2 * DATA_WIDTH_12;

  typedef enum logic [1:0] {StCollect, StDrain, StDone} state_e;

  state_e                     state_q, state_d;
  logic [EntryW-1:0]          mem_q [FIFO_DEPTH];
  logic [EntryW-1:0]          mem_d [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]            occ_q, occ_d;
  logic                       first_hit_q, first_hit_d;
  logic [DATA_WIDTH_12-1:0]   last_x_q, last_x_d;
  logic [DATA_WIDTH_12-1:0]   last_y_q, last_y_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       overflow_q, overflow_d;

  logic             empty, full, pop, hit, near, keep, push;
  logic [DiffW-1:0] dx, dy;

  // Hit qualification, merge test and FIFO push/pop decisions.
  always_comb begin
    empty = (occ_q == '0);
    full  = (occ_q == OccW'(FIFO_DEPTH));
    pop   = !empty && i_result_ready;
    hit   = (state_q == StCollect) && i_inspect_done && i_candidate;
    // One extra bit so the absolute difference never wraps.
    dx = (i_resize_x >= last_x_q) ? ({1'b0, i_resize_x} - {1'b0, last_x_q})
                                  : ({1'b0, last_x_q} - {1'b0, i_resize_x});
    dy = (i_resize_y >= last_y_q) ? ({1'b0, i_resize_y} - {1'b0, last_y_q})
                                  : ({1'b0, last_y_q} - {1'b0, i_resize_y});
    near = (dx <= DiffW'(MERGE_DIST)) && (dy <= DiffW'(MERGE_DIST));
    keep = hit && (first_hit_q || !near);
    // A pop in the same cycle frees the slot a full FIFO needs.
    push = keep && (!full || pop);
  end

  // Next-state for FIFO storage, pointers, merge history, counters and FSM.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    first_hit_d = first_hit_q;
    last_x_d    = last_x_q;
    last_y_d    = last_y_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    state_d     = state_q;

    if (push) begin
      mem_d[wr_ptr_q] = {i_resize_x, i_resize_y};
      wr_ptr_d        = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase

    // Last-kept position tracks every kept hit, even one that is dropped.
    if (keep) begin
      last_x_d    = i_resize_x;
      last_y_d    = i_resize_y;
      first_hit_d = 1'b0;
      if (!push) overflow_d = 1'b1;
    end

    unique case (state_q)
      StCollect: if (i_frame_end) state_d = StDrain;
      StDrain:   if (empty) state_d = StDone;
      StDone: begin
        state_d     = StCollect;
        count_d     = '0;
        overflow_d  = 1'b0;
        first_hit_d = 1'b1;
      end
      default:   state_d = StCollect;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      state_q     <= StCollect;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      first_hit_q <= 1'b1;
      last_x_q    <= '0;
      last_y_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      first_hit_q <= first_hit_d;
      last_x_q    <= last_x_d;
      last_y_q    <= last_y_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are masked by occupancy so no reset is needed.
  always_ff @(posedge clk_fpga) begin
    mem_q <= mem_d;
  end

  // Outputs derive only from registered state.
  always_comb begin
    o_result_valid = !empty;
    o_result_x     = empty ? '0 : mem_q[rd_ptr_q][EntryW-1:DATA_WIDTH_12];
    o_result_y     = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH_12-1:0];
    o_count        = count_q;
    o_overflow     = overflow_q;
    o_frame_done   = (state_q == StDone);
    o_busy         = (state_q != StCollect);
  end

endmodule

// File: tb/tb_candidate_collector.sv
// Bench for candidate_collector (FIFO_DEPTH=4): directed scenarios with fixed
// expectations plus a randomized run against a queue-based reference model.
module tb_candidate_collector;

  localparam int Depth = 4;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga, i_inspect_done, i_candidate, i_frame_end, i_result_ready;
  logic [11:0] i_resize_x, i_resize_y;
  logic        o_result_valid, o_overflow, o_frame_done, o_busy;
  logic [11:0] o_result_x, o_result_y, o_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frame phase 0=collecting, 1=draining, 2=done cycle.
  logic [23:0] mq[$];
  bit          m_first = 1'b1;
  int          m_lx, m_ly, m_count, m_phase;
  bit          m_ovf;

  candidate_collector #(
    .DATA_WIDTH_12  (12),
    .FIFO_DEPTH     (Depth),
    .FIFO_ADDR_WIDTH(2),
    .MERGE_DIST     (2),
    .COUNT_WIDTH    (12)
  ) dut (
    .clk_fpga      (clk_fpga),
    .reset_fpga    (reset_fpga),
    .i_inspect_done(i_inspect_done),
    .i_candidate   (i_candidate),
    .i_resize_x    (i_resize_x),
    .i_resize_y    (i_resize_y),
    .i_frame_end   (i_frame_end),
    .i_result_ready(i_result_ready),
    .o_result_valid(o_result_valid),
    .o_result_x    (o_result_x),
    .o_result_y    (o_result_y),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit rst, input bit dn, input bit cd, input logic [11:0] x,
                      input logic [11:0] y, input bit fe, input bit rd);
    int  sz, ph, ddx, ddy;
    bit  pop;
    reset_fpga = rst; i_inspect_done = dn; i_candidate = cd;
    i_resize_x = x; i_resize_y = y; i_frame_end = fe; i_result_ready = rd;
    @(posedge clk_fpga);
    if (!rst) begin
      mq.delete(); m_first = 1'b1; m_lx = 0; m_ly = 0; m_count = 0; m_ovf = 1'b0;
      m_phase = 0;
    end else begin
      sz  = mq.size();
      ph  = m_phase;
      pop = (sz != 0) && rd;
      if (pop) void'(mq.pop_front());
      if (ph == 0 && dn && cd) begin
        ddx = int'(x) - m_lx; if (ddx < 0) ddx = -ddx;
        ddy = int'(y) - m_ly; if (ddy < 0) ddy = -ddy;
        if (m_first || ddx > 2 || ddy > 2) begin
          m_lx = int'(x); m_ly = int'(y); m_first = 1'b0;
          if (sz < Depth || pop) begin
            mq.push_back({x, y});
            if (m_count < 4095) m_count++;
          end else m_ovf = 1'b1;
        end
      end
      if (ph == 0 && fe) m_phase = 1;
      else if (ph == 1 && sz == 0) m_phase = 2;
      else if (ph == 2) begin
        m_phase = 0; m_count = 0; m_ovf = 1'b0; m_first = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit rd);
    step(1, 0, 0, 12'd0, 12'd0, 0, rd);
  endtask

  task automatic hit(input int x, input int y, input bit rd);
    step(1, 1, 1, 12'(x), 12'(y), 0, rd);
  endtask

  task automatic test_reset;
    step(0, 0, 0, 12'd0, 12'd0, 0, 0);
    step(0, 0, 0, 12'd0, 12'd0, 0, 0);
    n_checks++; if (o_result_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", o_result_valid); else n_pass++;
    n_checks++; if (o_result_x !== 12'd0 || o_result_y !== 12'd0) $display("FAIL rst_xy got=%0d,%0d want=0,0", o_result_x, o_result_y); else n_pass++;
    n_checks++; if (o_count !== 12'd0 || o_overflow !== 1'b0) $display("FAIL rst_cnt_ovf got=%0d,%b want=0,0", o_count, o_overflow); else n_pass++;
    n_checks++; if (o_busy !== 1'b0 || o_frame_done !== 1'b0) $display("FAIL rst_busy_done got=%b,%b want=0,0", o_busy, o_frame_done); else n_pass++;
  endtask

  task automatic test_empty_frame;
    step(1, 0, 0, 12'd0, 12'd0, 1, 0);
    n_checks++; if (o_busy !== 1'b1 || o_frame_done !== 1'b0) $display("FAIL empty_c1 busy,done got=%b,%b want=1,0", o_busy, o_frame_done); else n_pass++;
    idle(0);
    n_checks++; if (o_busy !== 1'b1 || o_frame_done !== 1'b1) $display("FAIL empty_c2 busy,done got=%b,%b want=1,1", o_busy, o_frame_done); else n_pass++;
    n_checks++; if (o_count !== 12'd0) $display("FAIL empty_count got=%0d want=0", o_count); else n_pass++;
    idle(0);
    n_checks++; if (o_busy !== 1'b0 || o_frame_done !== 1'b0) $display("FAIL empty_c3 busy,done got=%b,%b want=0,0", o_busy, o_frame_done); else n_pass++;
  endtask

  task automatic test_merge;
    hit(10, 10, 1);
    n_checks++; if (o_result_valid !== 1'b1 || o_result_x !== 12'd10 || o_result_y !== 12'd10) $display("FAIL merge_first got=%b(%0d,%0d) want=1(10,10)", o_result_valid, o_result_x, o_result_y); else n_pass++;
    hit(11, 12, 1);
    n_checks++; if (o_result_valid !== 1'b0) $display("FAIL merge_suppressed valid got=%b want=0", o_result_valid); else n_pass++;
    hit(20, 10, 1);
    n_checks++; if (o_result_x !== 12'd20 || o_result_y !== 12'd10) $display("FAIL merge_second got=(%0d,%0d) want=(20,10)", o_result_x, o_result_y); else n_pass++;
    n_checks++; if (o_count !== 12'd2) $display("FAIL merge_count got=%0d want=2", o_count); else n_pass++;
    idle(1);
    n_checks++; if (o_result_valid !== 1'b0 || o_overflow !== 1'b0) $display("FAIL merge_drained valid,ovf got=%b,%b want=0,0", o_result_valid, o_overflow); else n_pass++;
    step(1, 0, 0, 12'd0, 12'd0, 1, 1);
    for (int i = 0; i < 40 && !o_frame_done; i++) idle(1);
    n_checks++; if (o_frame_done !== 1'b1 || o_count !== 12'd2) $display("FAIL merge_close done,count got=%b,%0d want=1,2", o_frame_done, o_count); else n_pass++;
    idle(1);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) begin
      hit(i * 10, 0, 0);
      n_checks++; if (o_result_valid !== 1'b1 || o_result_x !== 12'd0 || o_result_y !== 12'd0) $display("FAIL ovf_head[%0d] got=%b(%0d,%0d) want=1(0,0)", i, o_result_valid, o_result_x, o_result_y); else n_pass++;
      if (i == 3) begin
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL ovf_not_yet got=%b want=0", o_overflow); else n_pass++;
      end
    end
    n_checks++; if (o_count !== 12'd4 || o_overflow !== 1'b1) $display("FAIL ovf_state count,ovf got=%0d,%b want=4,1", o_count, o_overflow); else n_pass++;
    step(1, 0, 0, 12'd0, 12'd0, 1, 1);
    for (int k = 1; k < 4; k++) begin
      n_checks++; if (o_result_valid !== 1'b1 || o_result_x !== 12'(k * 10)) $display("FAIL ovf_pop[%0d] got=%b,%0d want=1,%0d", k, o_result_valid, o_result_x, k * 10); else n_pass++;
      idle(1);
    end
    n_checks++; if (o_result_valid !== 1'b0 || o_busy !== 1'b1 || o_frame_done !== 1'b0) $display("FAIL ovf_empty valid,busy,done got=%b,%b,%b want=0,1,0", o_result_valid, o_busy, o_frame_done); else n_pass++;
    idle(1);
    n_checks++; if (o_frame_done !== 1'b1 || o_count !== 12'd4 || o_overflow !== 1'b1) $display("FAIL ovf_done done,count,ovf got=%b,%0d,%b want=1,4,1", o_frame_done, o_count, o_overflow); else n_pass++;
    idle(1);
    n_checks++; if (o_count !== 12'd0 || o_overflow !== 1'b0 || o_busy !== 1'b0) $display("FAIL ovf_clear count,ovf,busy got=%0d,%b,%b want=0,0,0", o_count, o_overflow, o_busy); else n_pass++;
  endtask

  task automatic test_full_pop;
    int exp_x[3] = '{20, 30, 50};
    for (int i = 0; i < 4; i++) hit(i * 10, 0, 0);
    hit(50, 0, 1);
    n_checks++; if (o_count !== 12'd5 || o_overflow !== 1'b0) $display("FAIL fullpop count,ovf got=%0d,%b want=5,0", o_count, o_overflow); else n_pass++;
    n_checks++; if (o_result_x !== 12'd10) $display("FAIL fullpop_head got=%0d want=10", o_result_x); else n_pass++;
    step(1, 0, 0, 12'd0, 12'd0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_result_x !== 12'(exp_x[k])) $display("FAIL fullpop_order[%0d] got=%0d want=%0d", k, o_result_x, exp_x[k]); else n_pass++;
      idle(1);
    end
    for (int i = 0; i < 40 && !o_frame_done; i++) idle(1);
    n_checks++; if (o_frame_done !== 1'b1 || o_count !== 12'd5) $display("FAIL fullpop_close done,count got=%b,%0d want=1,5", o_frame_done, o_count); else n_pass++;
    idle(1);
  endtask

  task automatic test_frame_end_hit;
    step(1, 1, 1, 12'd5, 12'd5, 1, 0);
    n_checks++; if (o_result_valid !== 1'b1 || o_result_x !== 12'd5 || o_result_y !== 12'd5 || o_busy !== 1'b1) $display("FAIL fehit_entry got=%b(%0d,%0d) busy=%b want=1(5,5) busy=1", o_result_valid, o_result_x, o_result_y, o_busy); else n_pass++;
    step(1, 1, 1, 12'd100, 12'd100, 0, 0);
    n_checks++; if (o_count !== 12'd1 || o_frame_done !== 1'b0 || o_result_x !== 12'd5) $display("FAIL fehit_drain_hit count,done,x got=%0d,%b,%0d want=1,0,5", o_count, o_frame_done, o_result_x); else n_pass++;
    idle(1);
    n_checks++; if (o_result_valid !== 1'b0 || o_frame_done !== 1'b0) $display("FAIL fehit_popped valid,done got=%b,%b want=0,0", o_result_valid, o_frame_done); else n_pass++;
    idle(1);
    n_checks++; if (o_frame_done !== 1'b1 || o_count !== 12'd1) $display("FAIL fehit_done done,count got=%b,%0d want=1,1", o_frame_done, o_count); else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid_drain;
    hit(0, 0, 0); hit(10, 10, 0); hit(2, 2, 0);
    step(1, 0, 0, 12'd0, 12'd0, 1, 0);
    n_checks++; if (o_busy !== 1'b1 || o_count !== 12'd3) $display("FAIL rstd_pre busy,count got=%b,%0d want=1,3", o_busy, o_count); else n_pass++;
    step(0, 0, 0, 12'd0, 12'd0, 0, 0);
    n_checks++; if (o_result_valid !== 1'b0 || o_count !== 12'd0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) $display("FAIL rstd_after valid,count,busy,done got=%b,%0d,%b,%b want=0,0,0,0", o_result_valid, o_count, o_busy, o_frame_done); else n_pass++;
    idle(0);
    n_checks++; if (o_frame_done !== 1'b0) $display("FAIL rstd_nodone got=%b want=0", o_frame_done); else n_pass++;
    hit(1, 1, 0);
    n_checks++; if (o_result_valid !== 1'b1 || o_result_x !== 12'd1 || o_result_y !== 12'd1 || o_count !== 12'd1) $display("FAIL rstd_first got=%b(%0d,%0d) cnt=%0d want=1(1,1) cnt=1", o_result_valid, o_result_x, o_result_y, o_count); else n_pass++;
    step(1, 0, 0, 12'd0, 12'd0, 1, 1);
    for (int i = 0; i < 40 && !o_frame_done; i++) idle(1);
    n_checks++; if (o_frame_done !== 1'b1) $display("FAIL rstd_close got=%b want=1", o_frame_done); else n_pass++;
    idle(1);
  endtask

  task automatic test_random;
    logic [11:0] ex, ey;
    bit          rst;
    int          bad = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom % 250) != 0;
      step(rst, 1'($urandom % 2), 1'(($urandom % 3) != 0), 12'($urandom % 16),
           12'($urandom % 16), 1'(($urandom % 30) == 0), 1'(($urandom % 3) == 0));
      ex = (mq.size() != 0) ? mq[0][23:12] : 12'd0;
      ey = (mq.size() != 0) ? mq[0][11:0] : 12'd0;
      n_checks++;
      if (o_result_valid !== (mq.size() != 0) || o_result_x !== ex || o_result_y !== ey ||
          o_count !== 12'(m_count) || o_overflow !== m_ovf ||
          o_frame_done !== (m_phase == 2) || o_busy !== (m_phase != 0)) begin
        if (bad < 10) $display("FAIL random[%0d] got v=%b x=%0d y=%0d c=%0d o=%b d=%b b=%b want v=%b x=%0d y=%0d c=%0d o=%b d=%b b=%b",
          c, o_result_valid, o_result_x, o_result_y, o_count, o_overflow, o_frame_done, o_busy,
          mq.size() != 0, ex, ey, m_count, m_ovf, m_phase == 2, m_phase != 0);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    reset_fpga = 1'b0; i_inspect_done = 1'b0; i_candidate = 1'b0; i_frame_end = 1'b0;
    i_result_ready = 1'b0; i_resize_x = '0; i_resize_y = '0;
    test_reset();
    test_empty_frame();
    test_merge();
    test_overflow();
    test_full_pop();
    test_frame_end_hit();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/candidate_collector.md
Name: candidate_collector

Overview:
Downstream consumer of the window classifier's per-window verdict (inspect-done pulse, candidate flag, resized x/y).
- Suppresses near-duplicate hits against the last kept hit.
- Buffers surviving coordinates in a first-word-fall-through (FWFT) FIFO.
- Drains them to the OS-side reader through a valid/ready handshake.
- Marks each frame boundary with a done pulse, an accepted count and a sticky overflow flag.

Parameters:
DATA_WIDTH_12, 12, width of x/y coordinates
FIFO_DEPTH, 16, number of coordinate entries buffered (power of 2)
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH)
MERGE_DIST, 2, max |dx| and |dy| at which a hit is merged into the last kept hit
COUNT_WIDTH, 12, width of per-frame accepted-candidate counter

Ports:
clk_fpga  input  1  single clock, all logic on rising edge
reset_fpga  input  1  synchronous active-low reset
i_inspect_done  input  1  one-cycle pulse: classifier finished one window
i_candidate  input  1  window passed all stages; sampled only with i_inspect_done
i_resize_x  input  DATA_WIDTH_12  window x in resized frame; sampled with i_inspect_done
i_resize_y  input  DATA_WIDTH_12  window y in resized frame; sampled with i_inspect_done
i_frame_end  input  1  one-cycle pulse: last window of frame issued
i_result_ready  input  1  reader accepts head entry
o_result_valid  output  1  FIFO non-empty
o_result_x  output  DATA_WIDTH_12  head entry x; 0 when empty
o_result_y  output  DATA_WIDTH_12  head entry y; 0 when empty
o_count  output  COUNT_WIDTH  entries written this frame, saturating
o_overflow  output  1  sticky: a hit was dropped because the FIFO was full
o_frame_done  output  1  one-cycle pulse: frame closed and FIFO drained
o_busy  output  1  high in DRAIN/DONE; upstream must not issue windows

Behaviour:
- Reset (reset_fpga low at an edge):
  - State goes to COLLECT; FIFO pointers and occupancy go to 0.
  - first_hit=1; last_x/last_y=0.
  - All outputs go to 0.
  - Reset mid-frame or mid-drain discards all FIFO contents; no frame_done pulse is issued.
- States:
  - COLLECT: accept windows. On i_frame_end go to DRAIN.
  - DRAIN: o_busy=1; windows are ignored. When the FIFO is empty go to DONE.
  - DONE: lasts one cycle. o_frame_done=1, o_busy=1. At the next edge: clear o_count, o_overflow and first_hit; go to COLLECT.
- Hit evaluation in COLLECT, when i_inspect_done && i_candidate:
  - Suppressed if first_hit=0 && |x-last_x|<=MERGE_DIST && |y-last_y|<=MERGE_DIST. Compute each abs diff as unsigned, DATA_WIDTH_12+1 bits, so there is no wrap.
  - Otherwise the hit is kept: last_x/last_y <= x/y and first_hit <= 0, whether or not the write succeeds.
- Write rules for a kept hit:
  - Written if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise dropped and o_overflow <= 1.
  - o_count increments only on a write and saturates at all-ones.
- i_inspect_done with i_candidate=0 does nothing. i_candidate without i_inspect_done is ignored.
- i_frame_end in the same cycle as a hit: the hit is evaluated first, then the state moves to DRAIN.
- i_frame_end outside COLLECT is ignored.
- Latency: a hit written at edge N is visible at the output (o_result_valid=1 with its x/y) after edge N.
- Pop: occurs at an edge where o_result_valid && i_result_ready. The read pointer advances and the next entry appears after that edge.
- Empty FIFO with a write in the same cycle: no pop, because valid was 0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is FIFO_ADDR_WIDTH+1 bits.
  - full = occupancy==FIFO_DEPTH; empty = occupancy==0.
  - A simultaneous push and pop leaves occupancy unchanged.
- The DRAIN→DONE check uses registered occupancy==0. If a frame ends with an empty FIFO, DRAIN lasts exactly 1 cycle.
- o_count and o_overflow hold their frame's values through the o_frame_done cycle.

Test Plan:
- Reset, then i_frame_end with no windows → o_busy=1 for 2 cycles; o_frame_done pulses once, 2 cycles after frame_end; o_count=0.
- Hits (10,10), (11,12), (20,10) with ready=1 → outputs (10,10) then (20,10); (11,12) merged; o_count=2, o_overflow=0.
- FIFO_DEPTH=4, ready=0, hits at x=0,10,20,30,40 (y=0) → valid stays 1, head (0,0); o_count=4; o_overflow=1 after the 5th. Raise ready and end the frame → 4 pops in order, then the frame_done pulse.
- FIFO_DEPTH=4, FIFO full, hit at x=50 while ready=1 (pop in the same cycle) → hit written, o_overflow stays 0, o_count=5.
- Hit (5,5) and i_frame_end in the same cycle → entry (5,5) emitted; frame_done only after it is popped; a hit offered during DRAIN is not written.
- reset_fpga low mid-DRAIN with 3 entries → next cycle o_result_valid=0, o_count=0, state COLLECT, no frame_done pulse; the next frame's first hit (e.g. (1,1)) is kept even if near the old last_x/last_y.
